// File: rtl/seq_ser_pkg.sv
// Shared types and line levels for the byte serializer transmit path.
package seq_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_ser_bit_tick.sv
// Bit-period timer: tick is high on the last clock of every CLKS_PER_BIT-long bit.
module seq_ser_bit_tick
    import seq_ser_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   TW   = cnt_w(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    // With CLKS_PER_BIT = 1 the counter is pinned at zero, so tick fires every cycle.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seq_byte_serializer_tx.sv
// Parallel-to-serial frame transmitter: start, data LSB-first, optional even parity, stop.
module seq_byte_serializer_tx
    import seq_ser_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned   BW       = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BW-1:0]     bit_q;
    logic              parity_q;
    logic              tx_q;
    logic              tick;

    // The timer free-runs from zero once the frame leaves IDLE.
    seq_ser_bit_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign shift_d = shift_q >> 1;

    // tx_q is loaded together with the state change so the line level lines up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= IDLE_LVL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= START;
                        shift_q  <= in_data;
                        parity_q <= ^in_data;
                        bit_q    <= '0;
                        tx_q     <= START_LVL;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            if (PARITY_EN) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= STOP_LVL;
                            end
                        end else begin
                            shift_q <= shift_d;
                            bit_q   <= bit_q + BW'(1);
                            tx_q    <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= STOP_LVL;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LVL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LVL;
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

endmodule

// File: tb/tb_seq_byte_serializer_tx.sv
// Directed bench: default serializer (8 bits, 4 clk/bit, parity) plus a 1 clk/bit, no-parity instance.
module tb_seq_byte_serializer_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_a = 1'b0;
    logic [7:0] d_a = 8'h00;
    logic       rdy_a, tx_a, busy_a;
    logic       v_b = 1'b0;
    logic [7:0] d_b = 8'h00;
    logic       rdy_b, tx_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_byte_serializer_tx dut_a (
        .clk     (clk),
        .rst     (rst),
        .in_valid(v_a),
        .in_data (d_a),
        .in_ready(rdy_a),
        .tx      (tx_a),
        .busy    (busy_a)
    );

    seq_byte_serializer_tx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(1),
        .PARITY_EN   (1'b0)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .in_valid(v_b),
        .in_data (d_b),
        .in_ready(rdy_b),
        .tx      (tx_b),
        .busy    (busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (tx_a !== 1'b1)   begin n_bad++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        n_cmp++; if (rdy_a !== 1'b0)  begin n_bad++; $display("FAIL reset_rdy_a: got %b want 0", rdy_a); end
        n_cmp++; if (tx_b !== 1'b1)   begin n_bad++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
        rst = 1'b0;
        #1;
        n_cmp++; if (rdy_a !== 1'b1)  begin n_bad++; $display("FAIL reset_release_rdy: got %b want 1", rdy_a); end
        step();
    endtask

    task automatic test_a5();
        logic [10:0] seq = 11'b1_0_1010_0101_0;
        n_cmp++; if (rdy_a !== 1'b1)  begin n_bad++; $display("FAIL a5_rdy_n: got %b want 1", rdy_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL a5_busy_n: got %b want 0", busy_a); end
        v_a = 1'b1;
        d_a = 8'hA5;
        step();
        v_a = 1'b0;
        d_a = 8'h5A;
        for (int k = 1; k <= 44; k++) begin
            n_cmp++;
            if (tx_a !== seq[(k-1)/4]) begin
                n_bad++; $display("FAIL a5_tx cycle N+%0d: got %b want %b", k, tx_a, seq[(k-1)/4]);
            end
            n_cmp++;
            if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin
                n_bad++; $display("FAIL a5_busy cycle N+%0d: got busy=%b rdy=%b want busy=1 rdy=0", k, busy_a, rdy_a);
            end
            step();
        end
        n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL a5_rdy_n45: got %b want 1", rdy_a); end
        n_cmp++; if (tx_a !== 1'b1)  begin n_bad++; $display("FAIL a5_tx_n45: got %b want 1", tx_a); end
    endtask

    task automatic test_07();
        logic [10:0] seq = 11'b1_1_0000_0111_0;
        int busy_cnt = 0;
        v_a = 1'b1;
        d_a = 8'h07;
        step();
        v_a = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busy_a === 1'b1) busy_cnt++;
            n_cmp++;
            if (k <= 44) begin
                if (tx_a !== seq[(k-1)/4]) begin
                    n_bad++; $display("FAIL x07_tx cycle N+%0d: got %b want %b", k, tx_a, seq[(k-1)/4]);
                end
            end else if (tx_a !== 1'b1) begin
                n_bad++; $display("FAIL x07_idle_tx cycle N+%0d: got %b want 1", k, tx_a);
            end
            step();
        end
        n_cmp++; if (busy_cnt != 44) begin n_bad++; $display("FAIL x07_busy_len: got %0d want 44", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] seq0 = 11'b1_0_0000_0000_0;
        logic [10:0] seq1 = 11'b1_0_1111_1111_0;
        v_a = 1'b1;
        d_a = 8'h00;
        step();
        d_a = 8'hFF;
        n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_n1: got %b want 0", rdy_a); end
        for (int k = 1; k <= 44; k++) begin
            n_cmp++;
            if (tx_a !== seq0[(k-1)/4]) begin
                n_bad++; $display("FAIL b2b_tx0 cycle N+%0d: got %b want %b", k, tx_a, seq0[(k-1)/4]);
            end
            step();
        end
        n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_n45: got %b want 1", rdy_a); end
        n_cmp++; if (tx_a !== 1'b1)  begin n_bad++; $display("FAIL b2b_gap_tx: got %b want 1", tx_a); end
        step();
        v_a = 1'b0;
        d_a = 8'h00;
        for (int k = 1; k <= 44; k++) begin
            n_cmp++;
            if (tx_a !== seq1[(k-1)/4]) begin
                n_bad++; $display("FAIL b2b_tx1 cycle M+%0d: got %b want %b", k, tx_a, seq1[(k-1)/4]);
            end
            step();
        end
        n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_end: got %b want 1", rdy_a); end
    endtask

    task automatic test_reset_mid();
        v_a = 1'b1;
        d_a = 8'hA5;
        step();
        v_a = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        n_cmp++; if (rdy_a !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 0", rdy_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_rst_busy_before: got %b want 1", busy_a); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (tx_a !== 1'b1)   begin n_bad++; $display("FAIL mid_rst_tx: got %b want 1", tx_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
        n_cmp++; if (rdy_a !== 1'b1)  begin n_bad++; $display("FAIL mid_rst_rdy_after: got %b want 1", rdy_a); end
        for (int k = 0; k < 50; k++) begin
            n_cmp++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
                n_bad++; $display("FAIL mid_rst_residual cycle %0d: got tx=%b busy=%b want tx=1 busy=0", k, tx_a, busy_a);
            end
            step();
        end
    endtask

    task automatic test_valid_in_reset();
        rst = 1'b1;
        v_a = 1'b1;
        d_a = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (rdy_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
                n_bad++; $display("FAIL rst_valid cycle %0d: got rdy=%b tx=%b busy=%b want 0 1 0", k, rdy_a, tx_a, busy_a);
            end
        end
        rst = 1'b0;
        v_a = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            n_cmp++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
                n_bad++; $display("FAIL rst_valid_after cycle %0d: got tx=%b busy=%b want 1 0", k, tx_a, busy_a);
            end
        end
    endtask

    task automatic test_fast_no_parity();
        logic [9:0] seq = 10'b1_1010_0101_0;
        n_cmp++; if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL fast_rdy_n: got %b want 1", rdy_b); end
        v_b = 1'b1;
        d_b = 8'hA5;
        step();
        d_b = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            n_cmp++;
            if (tx_b !== seq[k-1]) begin
                n_bad++; $display("FAIL fast_tx cycle N+%0d: got %b want %b", k, tx_b, seq[k-1]);
            end
            n_cmp++;
            if (rdy_b !== 1'b0) begin
                n_bad++; $display("FAIL fast_rdy cycle N+%0d: got %b want 0", k, rdy_b);
            end
            step();
        end
        n_cmp++; if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL fast_rdy_n11: got %b want 1", rdy_b); end
        n_cmp++; if (tx_b !== 1'b1)  begin n_bad++; $display("FAIL fast_tx_n11: got %b want 1", tx_b); end
        step();
        v_b = 1'b0;
        n_cmp++; if (tx_b !== 1'b0 || busy_b !== 1'b1) begin
            n_bad++; $display("FAIL fast_second_start: got tx=%b busy=%b want 0 1", tx_b, busy_b);
        end
        repeat (12) step();
        n_cmp++; if (rdy_b !== 1'b1 || tx_b !== 1'b1) begin
            n_bad++; $display("FAIL fast_end_idle: got rdy=%b tx=%b want 1 1", rdy_b, tx_b);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_07();
        test_back_to_back();
        test_reset_mid();
        test_valid_in_reset();
        test_fast_no_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_byte_serializer_tx.md
# seq_byte_serializer_tx

Parallel-to-serial frame transmitter. Accepts one DATA_W-bit word per valid/ready handshake and drives it onto a single-bit line as an asynchronous-style frame: start bit, data LSB-first, optional even parity, stop bit, each held for CLKS_PER_BIT clocks. It is the transmit end of the byte capture path, producing the serial stream that the capture/deserialize side registers back into a word. It serves as a sequential-frontend benchmark covering FSM, counters and handshake elaboration.

## Interface
Parameters:
- DATA_W, 8, payload width in bits; legal range ≥1.
- CLKS_PER_BIT, 4, clocks per serial bit; legal range ≥1.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - in_ready = 1 and tx = 1.
  - When in_valid && in_ready at an edge, latch in_data into the shift register, clear the bit counters, and go to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0]; shift right once every CLKS_PER_BIT cycles.
  - After DATA_W bits, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY: tx = XOR of the latched word, giving even parity over data plus parity bit. Hold for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Output decode:
  - in_ready = (state == IDLE) && !rst.
  - busy = (state != IDLE).
  - tx is registered; no combinational path from in_data to tx.
- Counter widths:
  - Tick counter: $clog2(CLKS_PER_BIT) bits, with a minimum of 1.
  - Bit counter: $clog2(DATA_W) bits, with a minimum of 1.
  - The tick counter wraps at CLKS_PER_BIT−1. When CLKS_PER_BIT = 1, a tick fires every cycle.
- in_data and in_valid are ignored outside accepted handshakes. The latched word is unaffected by later changes to in_data.

## Timing
- Reset:
  - rst high at an edge → next cycle state = IDLE, tx = 1, busy = 0, shift register = 0.
  - While rst is high, in_ready = 0 and in_valid is ignored.
- Reset mid-frame aborts the frame; tx returns to 1 the cycle after the reset edge.
- Frame length F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
- Handshake accepted in cycle N:
  - tx = 0 in cycles N+1 … N+CLKS_PER_BIT.
  - Data bit i occupies cycles N+1+CLKS_PER_BIT×(1+i) onward.
  - The last STOP cycle is N+F.
  - IDLE, with in_ready = 1, is reached in cycle N+F+1.
- Back-to-back: with in_valid held high, the next accept is in cycle N+F+1. Minimum frame period is F+1 cycles, with exactly one idle-high cycle between frames.
- Latency from accept to first tx change is 1 cycle.

## Structure
- Package seq_ser_pkg holds:
  - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants START_LVL = 1'b0, STOP_LVL = 1'b1, IDLE_LVL = 1'b1.
- Sub-module seq_ser_bit_tick (parameter CLKS_PER_BIT):
  - Inputs: clk, rst, clear.
  - Output: tick, high on the last cycle of each bit period.
  - The top-level FSM, shift register and bit counter consume tick.

## Test plan
Defaults throughout (DATA_W = 8, CLKS_PER_BIT = 4, PARITY_EN = 1), so F = 44.
- Send 0xA5 → tx holds each level 4 cycles: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. in_ready returns high at N+45.
- Send 0x07 → data bits 1,1,1,0,0,0,0,0 and parity bit 1. busy is high for exactly 44 cycles.
- Hold in_valid high with 0x00 then 0xFF → second accept at N+45; tx = 1 for exactly one cycle between frames; parity 0 for both words.
- Assert rst in cycle N+10 of a frame → tx = 1, busy = 0, in_ready = 1 from the cycle after rst deasserts. No residual bits appear.
- in_valid high with 0x3C while rst is high → no frame is started and tx stays 1.
- Rerun 0xA5 with CLKS_PER_BIT = 1 and PARITY_EN = 0 → 10-cycle frame 0,1,0,1,0,0,1,0,1,1, with the next accept at N+11.
